// File: rtl/sram_resp.sv
// sram_resp: behavioural single-port SRAM responder with post-reset clear,
// read-path stuck-at fault injection and saturating status counters.
module sram_resp #(
  parameter int              AW       = 10,
  parameter int              DW       = 8,
  parameter int              RD_LAT   = 1,
  parameter logic [DW-1:0]   INIT_VAL = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s_cen,
  input  logic             s_wen,
  input  logic             s_oen,
  input  logic [AW-1:0]    s_addr,
  input  logic [DW-1:0]    s_ddata,
  output logic [DW-1:0]    s_qdata,
  input  logic             fault_en,
  input  logic [AW-1:0]    fault_addr,
  input  logic [DW-1:0]    fault_mask,
  input  logic [DW-1:0]    fault_val,
  output logic             init_busy,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  logic [DW-1:0] mem [DEPTH];

  logic          in_ready;
  logic          acc;
  logic          wr_acc;
  logic          rd_acc;
  logic          err_evt;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] rd_data;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Masked bits of a faulty location read back as their stuck value.
  function automatic logic [DW-1:0] apply_fault(input logic [DW-1:0] d,
                                                input logic          hit,
                                                input logic [DW-1:0] mask,
                                                input logic [DW-1:0] val);
    return hit ? ((d & ~mask) | (val & mask)) : d;
  endfunction

  assign in_ready  = (state_q == ST_READY);
  assign init_busy = (state_q == ST_INIT);
  assign acc       = ~s_cen;
  assign wr_acc    = in_ready & acc & ~s_wen;
  assign rd_acc    = in_ready & acc & s_wen & ~s_oen;
  // Any select during the clear, or a write with output enable also low.
  assign err_evt   = acc & (~in_ready | (~s_wen & ~s_oen));

  // The clear sweep and bus writes share the single array write port.
  assign mem_we    = ~in_ready | wr_acc;
  assign mem_waddr = in_ready ? s_addr  : ptr_q;
  assign mem_wdata = in_ready ? s_ddata : INIT_VAL;

  assign rd_data   = apply_fault(mem[s_addr], fault_en && (fault_addr == s_addr),
                                 fault_mask, fault_val);

  // State and clear-pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Clear sweep walks every address once, then the array is open for use.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (&ptr_q) state_d = ST_READY;
      end
      ST_READY: begin
        ptr_d = '0;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Array write port; contents are stored unmodified by fault injection.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Access and protocol-error counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      if (wr_acc)  wr_cnt  <= sat_inc(wr_cnt);
      if (rd_acc)  rd_cnt  <= sat_inc(rd_cnt);
      if (err_evt) err_cnt <= sat_inc(err_cnt);
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic          vld_p0;
      logic [DW-1:0] rd_data_p0;

      // Stage p0: capture the read result and its valid flag.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vld_p0 <= 1'b0;
        else          vld_p0 <= rd_acc;
      end

      // Stage p0 data carries no reset; vld_p0 qualifies it.
      always_ff @(posedge clk) begin
        if (rd_acc) rd_data_p0 <= rd_data;
      end

      // Stage p1: deliver to the bus.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    s_qdata <= '0;
        else if (vld_p0) s_qdata <= rd_data_p0;
      end
    end else begin : g_lat1
      // Single stage: deliver on the sampling edge.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    s_qdata <= '0;
        else if (rd_acc) s_qdata <= rd_data;
      end
    end
  endgenerate

endmodule

// File: tb/tb_sram_resp.sv
// tb_sram_resp: scoreboard bench driving an RD_LAT=1 and an RD_LAT=2
// (narrow counters) responder with the same bus traffic.
module tb_sram_resp;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;
  localparam int MAX1  = (1 << 16) - 1;
  localparam int MAX2  = (1 << 4) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          s_cen = 1'b1, s_wen = 1'b1, s_oen = 1'b1;
  logic [AW-1:0] s_addr = '0;
  logic [DW-1:0] s_ddata = '0;
  logic          f_en = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic [DW-1:0] f_mask = '0, f_val = '0;

  logic [DW-1:0] q1, q2;
  logic          busy1, busy2;
  logic [15:0]   wr1, rd1, er1;
  logic [3:0]    wr2, rd2, er2;

  sram_resp #(.AW(AW), .DW(DW), .RD_LAT(1), .INIT_VAL(8'h00), .CNT_W(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .s_cen(s_cen), .s_wen(s_wen), .s_oen(s_oen),
    .s_addr(s_addr), .s_ddata(s_ddata), .s_qdata(q1),
    .fault_en(f_en), .fault_addr(f_addr), .fault_mask(f_mask), .fault_val(f_val),
    .init_busy(busy1), .wr_cnt(wr1), .rd_cnt(rd1), .err_cnt(er1));

  sram_resp #(.AW(AW), .DW(DW), .RD_LAT(2), .INIT_VAL(8'h00), .CNT_W(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .s_cen(s_cen), .s_wen(s_wen), .s_oen(s_oen),
    .s_addr(s_addr), .s_ddata(s_ddata), .s_qdata(q2),
    .fault_en(f_en), .fault_addr(f_addr), .fault_mask(f_mask), .fault_val(f_val),
    .init_busy(busy2), .wr_cnt(wr2), .rd_cnt(rd2), .err_cnt(er2));

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int          due;
    bit          upd_q;
    logic [7:0]  qv;
    bit          wr;
    bit          rd;
    bit          err;
  } rec_t;

  rec_t sq1[$];
  rec_t sq2[$];

  // Reference state: array contents, last edge before the clear starts.
  logic [7:0] mem_m [DEPTH];
  int         rel_edge = 1 << 30;

  // Expected outputs as seen by the monitor.
  logic [7:0] exq [2];
  int         ew [2], er [2], ee [2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", name, edge_n, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic apply_rec(input rec_t r, input int i);
    int mx;
    mx = (i == 0) ? MAX1 : MAX2;
    if (r.upd_q) exq[i] = r.qv;
    if (r.wr)  ew[i] = sat(ew[i], mx);
    if (r.rd)  er[i] = sat(er[i], mx);
    if (r.err) ee[i] = sat(ee[i], mx);
  endtask

  // Monitor: retire due expectations, then compare every output.
  always @(negedge clk) begin
    if (reset_n) begin
      while (sq1.size() > 0 && sq1[0].due <= edge_n) apply_rec(sq1.pop_front(), 0);
      while (sq2.size() > 0 && sq2[0].due <= edge_n) apply_rec(sq2.pop_front(), 1);
      chk("qdata_lat1", int'(q1), int'(exq[0]));
      chk("qdata_lat2", int'(q2), int'(exq[1]));
      chk("busy_lat1", int'(busy1), int'(edge_n < rel_edge + DEPTH));
      chk("busy_lat2", int'(busy2), int'(edge_n < rel_edge + DEPTH));
      chk("wr_cnt1", int'(wr1), ew[0]);
      chk("rd_cnt1", int'(rd1), er[0]);
      chk("err_cnt1", int'(er1), ee[0]);
      chk("wr_cnt2", int'(wr2), ew[1]);
      chk("rd_cnt2", int'(rd2), er[1]);
      chk("err_cnt2", int'(er2), ee[1]);
    end
  end

  // One bus cycle: drive inputs, predict the effect of the next edge.
  task automatic bus(input bit cen, input bit wen, input bit oen,
                     input int addr, input int data);
    int   e;
    rec_t c, q;
    logic [7:0] v;
    e = edge_n + 1;
    s_cen = cen; s_wen = wen; s_oen = oen;
    s_addr = AW'(addr); s_ddata = DW'(data);
    c = '{due: e, upd_q: 1'b0, qv: 8'h00, wr: 1'b0, rd: 1'b0, err: 1'b0};
    if (!cen) begin
      if (e <= rel_edge + DEPTH) begin
        c.err = 1'b1;
      end else if (!wen) begin
        mem_m[addr] = DW'(data);
        c.wr  = 1'b1;
        c.err = !oen;
      end else if (!oen) begin
        v = mem_m[addr];
        if (f_en && f_addr == AW'(addr)) v = (v & ~f_mask) | (f_val & f_mask);
        c.rd = 1'b1;
        q = '{due: e, upd_q: 1'b1, qv: v, wr: 1'b0, rd: 1'b0, err: 1'b0};
        sq1.push_back(c); sq1.push_back(q);
        q.due = e + 1;
        sq2.push_back(c); sq2.push_back(q);
        @(negedge clk);
        return;
      end
    end
    sq1.push_back(c);
    sq2.push_back(c);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1, 1, 1, 0, 0);
  endtask

  task automatic wr(input int a, input int d);
    bus(0, 0, 1, a, d);
  endtask

  task automatic rd(input int a);
    bus(0, 1, 0, a, 0);
  endtask

  // Asynchronous reset shortly after a falling edge, released two cycles later.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_qdata_lat1", int'(q1), 0);
    chk("rst_qdata_lat2", int'(q2), 0);
    chk("rst_busy_lat1", int'(busy1), 1);
    chk("rst_busy_lat2", int'(busy2), 1);
    chk("rst_cnt_lat1", int'(wr1) + int'(rd1) + int'(er1), 0);
    chk("rst_cnt_lat2", int'(wr2) + int'(rd2) + int'(er2), 0);
    sq1.delete();
    sq2.delete();
    for (int i = 0; i < 2; i++) begin
      exq[i] = 8'h00; ew[i] = 0; er[i] = 0; ee[i] = 0;
    end
    for (int a = 0; a < DEPTH; a++) mem_m[a] = 8'h00;
    repeat (2) @(negedge clk);
    rel_edge = edge_n;
    reset_n  = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Clear sweep with three illegal writes in the middle of it.
    idle(10);
    for (int i = 0; i < 3; i++) bus(0, 0, 1, 'h005, 'h77);
    idle(DEPTH - 13);
    rd('h3FF);
    rd('h005);
    idle(2);

    // Fill and read back the whole array; narrow counters saturate.
    for (int a = 0; a < DEPTH; a++) wr(a, 'h5A);
    for (int a = 0; a < DEPTH; a++) rd(a);
    idle(2);

    // Stuck-at fault on the read path only.
    wr('h123, 'hA5);
    f_en = 1'b1; f_addr = 'h123; f_mask = 8'h0F; f_val = 8'h00;
    rd('h123);
    f_en = 1'b0;
    rd('h123);
    idle(2);

    // Write with output enable also low: write lands, read suppressed.
    bus(0, 0, 0, 'h010, 'hFF);
    idle(2);
    rd('h010);
    bus(0, 1, 1, 'h010, 0);
    idle(2);

    // Back-to-back reads, write-then-read on consecutive cycles.
    wr('h001, 'h11);
    wr('h002, 'h22);
    rd('h001);
    rd('h002);
    wr('h003, 'h33);
    rd('h003);
    idle(3);

    // Random traffic with faults on a small address window.
    for (int i = 0; i < 1500; i++) begin
      int k;
      k = int'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) begin
        f_en   = $urandom_range(0, 1) == 1;
        f_addr = AW'($urandom_range(0, 7));
        f_mask = DW'($urandom);
        f_val  = DW'($urandom);
      end
      if (k < 2)       idle(1);
      else if (k < 5)  wr(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
      else if (k < 9)  rd(int'($urandom_range(0, 15)));
      else             bus(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                           int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 255)));
    end
    f_en = 1'b0;
    idle(3);

    // Reset while a second-stage read is still in flight.
    wr('h001, 'h11);
    wr('h002, 'h22);
    rd('h001);
    rd('h002);
    do_reset();
    idle(DEPTH + 2);
    rd('h002);
    wr('h002, 'h99);
    rd('h002);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
